// File: rtl/gzip_stream_parser_pkg.sv
// rtl/gzip_stream_parser_pkg.sv - types, constants and helpers shared by the gzip parser files
`include "gzip_defs.vh"

package gzip_stream_parser_pkg;

  typedef enum logic [1:0] {
    ST_HDR    = 2'd0,
    ST_BODY   = 2'd1,
    ST_ERR    = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam logic [7:0] ID1      = `GZIP_ID1;
  localparam logic [7:0] ID2      = `GZIP_ID2;
  localparam logic [7:0] CM_DEFL  = `GZIP_CM_DEFLATE;
  localparam logic [7:0] FLG_NONE = 8'h00;
  localparam int         HDR_LEN  = `GZIP_HDR_LEN;
  localparam int         FTR_LEN  = `GZIP_FTR_LEN;

  // Number of bytes taken from a beat; only the final beat is trimmed by tkeep
  function automatic logic [2:0] keep_to_count(input logic last, input logic [3:0] keep);
    if (!last) return 3'd4;
    case (keep)
      4'b0001: return 3'd1;
      4'b0011: return 3'd2;
      4'b0111: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  // Fixed header fields: ID1, ID2, CM=deflate and FLG with no optional fields
  function automatic logic hdr_byte_ok(input logic [3:0] idx, input logic [7:0] b);
    case (idx)
      4'd0:    return b == ID1;
      4'd1:    return b == ID2;
      4'd2:    return b == CM_DEFL;
      4'd3:    return b == FLG_NONE;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/axis32_to_byte.sv
// rtl/axis32_to_byte.sv - holds one 32-bit beat and hands it out one byte per clock, low byte first
module axis32_to_byte
  import gzip_stream_parser_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        i_tready,
  input  logic        i_tvalid,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic [3:0]  i_tkeep,
  output logic        b_valid,
  output logic [7:0]  b_data,
  output logic        b_last,
  input  logic        b_ready
);

  logic [31:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        take, load;

  // Byte presentation, beat acceptance and next beat-register contents
  always_comb begin
    b_valid  = (cnt_q != 3'd0);
    b_data   = data_q[7:0];
    b_last   = last_q && (cnt_q == 3'd1);
    take     = b_valid && b_ready;
    // A new beat may land in the same cycle the old one gives up its final byte
    i_tready = !rst && en && ((cnt_q == 3'd0) || ((cnt_q == 3'd1) && take));
    load     = i_tvalid && i_tready;
    data_d   = data_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (take) begin
      data_d = {8'h00, data_q[31:8]};
      cnt_d  = cnt_q - 3'd1;
    end
    if (load) begin
      data_d = i_tdata;
      cnt_d  = keep_to_count(i_tlast, i_tkeep);
      last_d = i_tlast;
    end
  end

  // Beat register state
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/gzip_defs.vh
// rtl/gzip_defs.vh - GZIP container constants shared by the parser and the compressor
`ifndef GZIP_DEFS_VH
`define GZIP_DEFS_VH

`define GZIP_ID1        8'h1F
`define GZIP_ID2        8'h8B
`define GZIP_CM_DEFLATE 8'h08
`define GZIP_HDR_LEN    10
`define GZIP_FTR_LEN    8

`endif

// File: rtl/gzip_stream_parser.sv
// rtl/gzip_stream_parser.sv - strips GZIP header/footer, streams deflate payload, reports footer; GZIP_PARSER_HDR_CHECK_EN enables header ID checks
module gzip_stream_parser
  import gzip_stream_parser_pkg::*;
#(
  parameter int SIMULATION = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i_tready,
  input  logic        i_tvalid,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic [3:0]  i_tkeep,
  input  logic        o_tready,
  output logic        o_tvalid,
  output logic [7:0]  o_tdata,
  output logic        o_tlast,
  output logic        f_valid,
  output logic [31:0] f_crc,
  output logic [31:0] f_isize,
  output logic        f_err
);

  state_e      state_q, state_d;
  logic [3:0]  hcnt_q, hcnt_d;
  logic [3:0]  lcnt_q, lcnt_d;
  logic [7:0]  line_q [FTR_LEN];
  logic [7:0]  line_d [FTR_LEN];
  logic        o_tvalid_q, o_tvalid_d;
  logic [7:0]  o_tdata_q, o_tdata_d;
  logic        o_tlast_q, o_tlast_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] f_crc_q, f_crc_d;
  logic [31:0] f_isize_q, f_isize_d;
  logic        f_err_q, f_err_d;

  logic        unpack_en;
  logic        b_valid, b_last, b_ready;
  logic [7:0]  b_data;
  logic        out_load, line_full;

  assign unpack_en = (state_q != ST_REPORT);

  axis32_to_byte u_unpack (
    .clk      (clk),
    .rst      (rst),
    .en       (unpack_en),
    .i_tready (i_tready),
    .i_tvalid (i_tvalid),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tkeep  (i_tkeep),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_last   (b_last),
    .b_ready  (b_ready)
  );

  // Parser FSM next state: header skip, footer delay line, output register and report
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    lcnt_d     = lcnt_q;
    line_d     = line_q;
    o_tvalid_d = o_tvalid_q;
    o_tdata_d  = o_tdata_q;
    o_tlast_d  = o_tlast_q;
    f_valid_d  = 1'b0;
    f_crc_d    = f_crc_q;
    f_isize_d  = f_isize_q;
    f_err_d    = f_err_q;
    b_ready    = 1'b0;
    out_load   = !o_tvalid_q || o_tready;
    line_full  = (lcnt_q == 4'(FTR_LEN));

    if (out_load) begin
      o_tvalid_d = 1'b0;
      o_tlast_d  = 1'b0;
    end

    case (state_q)
      ST_HDR: begin
        b_ready = 1'b1;
        if (b_valid) begin
          if (b_last) begin
            state_d   = ST_REPORT;
            f_valid_d = 1'b1;
            f_err_d   = 1'b1;
          end
`ifdef GZIP_PARSER_HDR_CHECK_EN
          else if (!hdr_byte_ok(hcnt_q, b_data)) begin
            state_d = ST_ERR;
          end
`endif
          else if (hcnt_q == 4'(HDR_LEN - 1)) begin
            state_d = ST_BODY;
          end else begin
            hcnt_d = hcnt_q + 4'd1;
          end
        end
      end

      ST_BODY: begin
        // A push into a full line evicts a byte, so it needs room in the output register
        b_ready = !line_full || out_load;
        if (b_valid && b_ready) begin
          if (line_full) begin
            o_tvalid_d = 1'b1;
            o_tdata_d  = line_q[0];
            o_tlast_d  = b_last;
            for (int i = 0; i < FTR_LEN - 1; i++) begin
              line_d[i] = line_q[i + 1];
            end
            line_d[FTR_LEN - 1] = b_data;
          end else begin
            line_d[lcnt_q[2:0]] = b_data;
            lcnt_d = lcnt_q + 4'd1;
          end
          if (b_last) begin
            // With the line not already full, either the footer is short or no payload left
            state_d   = ST_REPORT;
            f_valid_d = 1'b1;
            f_err_d   = !line_full;
            f_crc_d   = {line_d[3], line_d[2], line_d[1], line_d[0]};
            f_isize_d = {line_d[7], line_d[6], line_d[5], line_d[4]};
          end
        end
      end

      ST_ERR: begin
        b_ready = 1'b1;
        if (b_valid && b_last) begin
          state_d   = ST_REPORT;
          f_valid_d = 1'b1;
          f_err_d   = 1'b1;
        end
      end

      ST_REPORT: begin
        state_d = ST_HDR;
        hcnt_d  = 4'd0;
        lcnt_d  = 4'd0;
        for (int i = 0; i < FTR_LEN; i++) begin
          line_d[i] = 8'h00;
        end
      end

      default: state_d = ST_HDR;
    endcase
  end

  // Parser state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HDR;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      line_q     <= '{default: 8'h00};
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      o_tlast_q  <= 1'b0;
      f_valid_q  <= 1'b0;
      f_crc_q    <= '0;
      f_isize_q  <= '0;
      f_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      line_q     <= line_d;
      o_tvalid_q <= o_tvalid_d;
      o_tdata_q  <= o_tdata_d;
      o_tlast_q  <= o_tlast_d;
      f_valid_q  <= f_valid_d;
      f_crc_q    <= f_crc_d;
      f_isize_q  <= f_isize_d;
      f_err_q    <= f_err_d;
    end
  end

  assign o_tvalid = o_tvalid_q;
  assign o_tdata  = o_tdata_q;
  assign o_tlast  = o_tlast_q;
  assign f_valid  = f_valid_q;
  assign f_crc    = f_crc_q;
  assign f_isize  = f_isize_q;
  assign f_err    = f_err_q;

  generate
    if (SIMULATION != 0) begin : g_sim_assert
      // Non-final beats are always consumed whole, so a partial tkeep there is an upstream bug
      always_ff @(posedge clk) begin
        if (!rst && i_tvalid && i_tready && !i_tlast) begin
          assert (i_tkeep == 4'hF);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_gzip_stream_parser.sv
// tb/tb_gzip_stream_parser.sv - scoreboard bench for gzip_stream_parser
`timescale 1ns/1ps
module tb_gzip_stream_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tready;
  logic        i_tvalid = 1'b0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic [3:0]  i_tkeep = '0;
  logic        o_tready = 1'b1;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic        f_valid;
  logic [31:0] f_crc;
  logic [31:0] f_isize;
  logic        f_err;

  gzip_stream_parser #(.SIMULATION(1)) dut (
    .clk(clk), .rst(rst),
    .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tkeep(i_tkeep),
    .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tlast(o_tlast),
    .f_valid(f_valid), .f_crc(f_crc), .f_isize(f_isize), .f_err(f_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] crc;
    logic [31:0] isize;
    logic        err;
    logic        chk;
  } ftr_t;

  logic [8:0] exp_q[$];
  ftr_t       fexp_q[$];
  logic [7:0] stm[$];
  logic [7:0] raw[1000];
  ftr_t       mon_e;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         rmode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: output bytes and footer reports against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (o_tvalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_byte: got %h last=%b, required no byte", o_tdata, o_tlast);
        end else begin
          check("out_byte", {23'd0, o_tlast, o_tdata}, {23'd0, exp_q[0]});
          if (o_tready) void'(exp_q.pop_front());
        end
      end
      if (f_valid) begin
        check("tready_in_report", {31'd0, i_tready}, 32'd0);
        if (fexp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_report: got f_valid err=%b, required no report", f_err);
        end else begin
          mon_e = fexp_q.pop_front();
          check("f_err", {31'd0, f_err}, {31'd0, mon_e.err});
          if (mon_e.chk) begin
            check("f_crc", f_crc, mon_e.crc);
            check("f_isize", f_isize, mon_e.isize);
          end
        end
      end
    end
  end

  // Output backpressure: 0 = always ready, 1 = random, 2 = driven by the test
  initial forever begin
    @(posedge clk);
    #1;
    if (rmode == 0) o_tready = 1'b1;
    else if (rmode == 1) o_tready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic put_hdr(input logic [7:0] b1);
    stm.push_back(8'h1F); stm.push_back(b1); stm.push_back(8'h08); stm.push_back(8'h00);
    for (int i = 0; i < 5; i++) stm.push_back(8'h00);
    stm.push_back(8'hFF);
  endtask

  task automatic put_ftr(input logic [31:0] crc, input logic [31:0] isize);
    for (int i = 0; i < 4; i++) stm.push_back(crc[8*i +: 8]);
    for (int i = 0; i < 4; i++) stm.push_back(isize[8*i +: 8]);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic [3:0] k, output bit ok);
    int n = 0;
    ok = 1'b0;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l; i_tkeep = k;
    while (n < 3000) begin
      @(negedge clk);
      if (i_tready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      n++;
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((exp_q.size() != 0 || fexp_q.size() != 0) && c < 5000) begin
      @(posedge clk);
      c++;
    end
    if (c >= 5000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d bytes %0d reports pending, required 0", exp_q.size(), fexp_q.size());
      exp_q.delete(); fexp_q.delete();
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Sends stm as a stream, queuing the bytes and footer report the spec demands
  task automatic run_stream(input logic [3:0] last_keep, input bit hdr_bad);
    int n;
    bit err, ok, lst;
    logic [31:0] d;
    ftr_t e;
    n = stm.size();
    err = (n <= 18);
`ifdef GZIP_PARSER_HDR_CHECK_EN
    if (hdr_bad) err = 1'b1;
`else
    if (hdr_bad) $display("note: header check disabled, malformed header parses normally");
`endif
    if (!err) for (int i = 10; i < n - 8; i++) exp_q.push_back({(i == n - 9), stm[i]});
    e = '0;
    if (n >= 8) begin
      e.crc   = {stm[n-5], stm[n-6], stm[n-7], stm[n-8]};
      e.isize = {stm[n-1], stm[n-2], stm[n-3], stm[n-4]};
    end
    e.err = err;
    e.chk = !err;
    fexp_q.push_back(e);
    for (int b = 0; b < n; b += 4) begin
      d = 32'hAAAA_AAAA;
      for (int j = 0; j < 4; j++) if (b + j < n) d[8*j +: 8] = stm[b + j];
      lst = (b + 4 >= n);
      send_beat(d, lst, lst ? last_keep : 4'hF, ok);
      if (!ok) begin
        n_cmp++; n_fail++;
        $display("FAIL beat_timeout: got i_tready low at byte %0d, required acceptance", b);
        break;
      end
    end
    stm.delete();
    wait_idle();
  endtask

  function automatic logic [31:0] crc32_raw();
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < 1000; i++) begin
      c ^= {24'd0, raw[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  initial begin
    bit ok;
    logic [31:0] d;
    // Reset values while a beat is offered
    rst = 1'b1; i_tvalid = 1'b1; i_tdata = 32'h1234_5678; i_tkeep = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_tready", {31'd0, i_tready}, 32'd0);
    check("rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
    check("rst_o_tdata", {24'd0, o_tdata}, 32'd0);
    check("rst_o_tlast", {31'd0, o_tlast}, 32'd0);
    check("rst_f_valid", {31'd0, f_valid}, 32'd0);
    check("rst_f_crc", f_crc, 32'd0);
    check("rst_f_isize", f_isize, 32'd0);
    check("rst_f_err", {31'd0, f_err}, 32'd0);
    i_tvalid = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;

    // Minimal stream: payload 03 00, zero footer
    put_hdr(8'h8B); stm.push_back(8'h03); stm.push_back(8'h00); put_ftr(32'h0, 32'h0);
    run_stream(4'b1111, 1'b0);

    // Same stream, output stalled 20 cycles after the first byte appears
    rmode = 2; o_tready = 1'b0;
    put_hdr(8'h8B); stm.push_back(8'h03); stm.push_back(8'h00); put_ftr(32'h0, 32'h0);
    fork
      run_stream(4'b1111, 1'b0);
      begin
        int c = 0;
        while (!o_tvalid && c < 500) begin @(negedge clk); c++; end
        if (!o_tvalid) begin
          n_cmp++; n_fail++;
          $display("FAIL stall_wait: got o_tvalid=0, required first byte");
        end
        repeat (20) @(posedge clk);
        #1;
        o_tready = 1'b1;
      end
    join
    rmode = 0;

    // 15 bytes, last tkeep 0111: short footer
    put_hdr(8'h8B); for (int i = 0; i < 5; i++) stm.push_back(8'h11 + 8'(i));
    run_stream(4'b0111, 1'b0);

    // 18 bytes: footer complete but no payload
    put_hdr(8'h8B); put_ftr(32'hCAFE_F00D, 32'h0);
    run_stream(4'b0011, 1'b0);

    // 19 bytes: single payload byte
    put_hdr(8'h8B); stm.push_back(8'h5A); put_ftr(32'h1122_3344, 32'h1);
    run_stream(4'b0111, 1'b0);

    // 20 bytes, last tkeep 1010 counts as 4 bytes
    put_hdr(8'h8B); stm.push_back(8'hA1); stm.push_back(8'hB2); put_ftr(32'hDEAD_BEEF, 32'h2);
    run_stream(4'b1010, 1'b0);

    // 17 bytes, last tkeep 0001
    put_hdr(8'h8B); for (int i = 0; i < 7; i++) stm.push_back(8'h60 + 8'(i));
    run_stream(4'b0001, 1'b0);

    // Stream ends inside the header
    put_hdr(8'h8B); void'(stm.pop_back()); void'(stm.pop_back());
    run_stream(4'b1111, 1'b0);

    // Header ID2 = 8C
    put_hdr(8'h8C); stm.push_back(8'h7E); stm.push_back(8'h7F); stm.push_back(8'h80);
    put_ftr(32'h0102_0304, 32'h3);
    run_stream(4'b0001, 1'b1);

    // Stored-block deflate of 1000 bytes, random backpressure
    for (int i = 0; i < 1000; i++) raw[i] = 8'((i * 37 + 11) ^ (i >> 3));
    put_hdr(8'h8B);
    stm.push_back(8'h01); stm.push_back(8'hE8); stm.push_back(8'h03);
    stm.push_back(8'h17); stm.push_back(8'hFC);
    for (int i = 0; i < 1000; i++) stm.push_back(raw[i]);
    put_ftr(crc32_raw(), 32'd1000);
    rmode = 1;
    run_stream(4'b0111, 1'b0);
    rmode = 0;

    // Reset while the body holds 5 bytes; nothing may be reported for it
    put_hdr(8'h8B); for (int i = 0; i < 6; i++) stm.push_back(8'hC0 + 8'(i));
    for (int b = 0; b < 16; b += 4) begin
      d = {stm[b+3], stm[b+2], stm[b+1], stm[b]};
      send_beat(d, 1'b0, 4'hF, ok);
      if (!ok) begin
        n_cmp++; n_fail++;
        $display("FAIL abort_beat_timeout: got i_tready low, required acceptance");
      end
    end
    stm.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_i_tready", {31'd0, i_tready}, 32'd0);
    check("mid_rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
    check("mid_rst_f_valid", {31'd0, f_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    put_hdr(8'h8B); for (int i = 0; i < 4; i++) stm.push_back(8'h40 + 8'(i));
    put_ftr(32'h89AB_CDEF, 32'h4);
    run_stream(4'b0011, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
